// File: rtl/bd_cpld_unpacker_pkg.sv
// Shared constants, error codes and FSM encoding for the CplD descriptor unpacker.
// Everything here is common to the header decoder and the unpacker top.
package bd_cpld_unpacker_pkg;

    localparam logic [2:0]  CPLD_FMT      = 3'b010;
    localparam logic [4:0]  CPLD_TYPE     = 5'b01010;
    localparam int unsigned BD_DW_DEFAULT = 8;
    // Tail beat carries the last three payload DWs of an 8-DW descriptor.
    localparam logic [7:0]  TAIL_KEEP     = 8'h07;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_HDR    = 2'd1,
        ERR_STATUS = 2'd2,
        ERR_FRAME  = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAIL = 2'd1,
        ST_OUT  = 2'd2,
        ST_DROP = 2'd3
    } state_e;

endpackage

// File: rtl/cpld_hdr_decode.sv
// Combinational CplD header field extraction and acceptance flags.
// Looks only at the 3-DW header in the low 96 bits of the head beat.
module cpld_hdr_decode
    import bd_cpld_unpacker_pkg::*;
#(
    parameter int unsigned BD_DW = BD_DW_DEFAULT
) (
    input  logic [95:0] hdr,
    output logic [7:0]  tag,
    output logic        hdr_ok,
    output logic        status_ok
);

    localparam logic [9:0] LEN_EXP = 10'(BD_DW);

    logic [2:0] fmt;
    logic [4:0] tlp_type;
    logic [9:0] length;
    logic [2:0] status;
    logic       unused_hdr_bits;

    assign fmt      = hdr[31:29];
    assign tlp_type = hdr[28:24];
    assign length   = hdr[9:0];
    assign status   = hdr[47:45];
    assign tag      = hdr[79:72];

    assign hdr_ok    = (fmt == CPLD_FMT) && (tlp_type == CPLD_TYPE) && (length == LEN_EXP);
    assign status_ok = (status == 3'd0);

    // Requester/completer IDs, byte count and address fields are not needed here.
    assign unused_hdr_bits = ^{hdr[95:80], hdr[71:48], hdr[44:32], hdr[23:10]};

endmodule

// File: rtl/bd_cpld_unpacker.sv
// Reassembles a two-beat CplD into one 256-bit buffer descriptor with its tag,
// dropping malformed or failed completions and reporting why.
module bd_cpld_unpacker
    import bd_cpld_unpacker_pkg::*;
#(
    parameter int unsigned BD_DW = BD_DW_DEFAULT
) (
    input  logic         user_clk,
    input  logic         user_reset,
    input  logic [255:0] m_axis_rx_cpld_tdata,
    input  logic         m_axis_rx_cpld_tvalid,
    output logic         m_axis_rx_cpld_tready,
    input  logic         m_axis_rx_cpld_tlast,
    input  logic [7:0]   m_axis_rx_cpld_tkeep,
    output logic [255:0] s_axis_bd_tdata,
    output logic         s_axis_bd_tvalid,
    input  logic         s_axis_bd_tready,
    output logic [7:0]   s_axis_bd_tag,
    output logic         err_valid,
    output logic [1:0]   err_code,
    output logic [15:0]  cpl_count
);

    state_e       state, state_next;
    err_code_e    err_sel;
    logic         ready_q;
    logic         beat_acc;
    logic         bd_hs;
    logic         tail_ok;
    logic         load_head;
    logic         load_bd;
    logic [7:0]   hdr_tag;
    logic         hdr_ok;
    logic         status_ok;
    logic [159:0] head_q;
    logic [7:0]   head_tag_q;
    logic [15:0]  cpl_count_q;

    cpld_hdr_decode #(
        .BD_DW (BD_DW)
    ) u_hdr_decode (
        .hdr       (m_axis_rx_cpld_tdata[95:0]),
        .tag       (hdr_tag),
        .hdr_ok    (hdr_ok),
        .status_ok (status_ok)
    );

    // ready_q keeps the input closed while reset is held.
    assign m_axis_rx_cpld_tready = ready_q && (state != ST_OUT);
    assign s_axis_bd_tvalid      = (state == ST_OUT);
    assign beat_acc              = m_axis_rx_cpld_tvalid && m_axis_rx_cpld_tready;
    assign bd_hs                 = s_axis_bd_tvalid && s_axis_bd_tready;
    assign tail_ok               = m_axis_rx_cpld_tlast && (m_axis_rx_cpld_tkeep == TAIL_KEEP);
    assign cpl_count             = cpl_count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        err_sel    = ERR_NONE;
        load_head  = 1'b0;
        load_bd    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (beat_acc) begin
                    if (!hdr_ok) begin
                        err_sel = ERR_HDR;
                    end else if (!status_ok) begin
                        err_sel = ERR_STATUS;
                    end else if (m_axis_rx_cpld_tlast) begin
                        err_sel = ERR_FRAME;
                    end else begin
                        load_head  = 1'b1;
                        state_next = ST_TAIL;
                    end
                    if (err_sel != ERR_NONE && !m_axis_rx_cpld_tlast) begin
                        state_next = ST_DROP;
                    end
                end
            end
            ST_TAIL: begin
                if (beat_acc) begin
                    if (tail_ok) begin
                        load_bd    = 1'b1;
                        state_next = ST_OUT;
                    end else begin
                        err_sel    = ERR_FRAME;
                        state_next = m_axis_rx_cpld_tlast ? ST_IDLE : ST_DROP;
                    end
                end
            end
            ST_OUT: begin
                if (bd_hs) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (beat_acc && m_axis_rx_cpld_tlast) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: descriptor and head registers are reset too, so the output bus reads zero after reset.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            ready_q         <= 1'b0;
            head_q          <= '0;
            head_tag_q      <= '0;
            s_axis_bd_tdata <= '0;
            s_axis_bd_tag   <= '0;
            err_valid       <= 1'b0;
            err_code        <= ERR_NONE;
            cpl_count_q     <= '0;
        end else begin
            ready_q   <= 1'b1;
            err_valid <= (err_sel != ERR_NONE);
            if (err_sel != ERR_NONE) begin
                err_code <= err_sel;
            end
            if (load_head) begin
                head_q     <= m_axis_rx_cpld_tdata[255:96];
                head_tag_q <= hdr_tag;
            end
            if (load_bd) begin
                s_axis_bd_tdata <= {m_axis_rx_cpld_tdata[95:0], head_q};
                s_axis_bd_tag   <= head_tag_q;
            end
            if (bd_hs) begin
                cpl_count_q <= cpl_count_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_bd_cpld_unpacker.sv
// Self-checking bench for bd_cpld_unpacker: vector table of CplD frames plus
// hand-written backpressure, mid-frame reset and counter-wrap sequences.
module tb_bd_cpld_unpacker;

    localparam logic [2:0] F_OK = 3'b010;
    localparam logic [4:0] T_OK = 5'b01010;

    logic         user_clk = 1'b0;
    logic         user_reset = 1'b1;
    logic [255:0] rx_tdata = '0;
    logic         rx_tvalid = 1'b0;
    logic         rx_tready;
    logic         rx_tlast = 1'b0;
    logic [7:0]   rx_tkeep = '0;
    logic [255:0] bd_tdata;
    logic         bd_tvalid;
    logic         bd_tready = 1'b1;
    logic [7:0]   bd_tag;
    logic         err_valid;
    logic [1:0]   err_code;
    logic [15:0]  cpl_count;

    always #5 user_clk = ~user_clk;

    bd_cpld_unpacker #(.BD_DW(8)) dut (
        .user_clk              (user_clk),
        .user_reset            (user_reset),
        .m_axis_rx_cpld_tdata  (rx_tdata),
        .m_axis_rx_cpld_tvalid (rx_tvalid),
        .m_axis_rx_cpld_tready (rx_tready),
        .m_axis_rx_cpld_tlast  (rx_tlast),
        .m_axis_rx_cpld_tkeep  (rx_tkeep),
        .s_axis_bd_tdata       (bd_tdata),
        .s_axis_bd_tvalid      (bd_tvalid),
        .s_axis_bd_tready      (bd_tready),
        .s_axis_bd_tag         (bd_tag),
        .err_valid             (err_valid),
        .err_code              (err_code),
        .cpl_count             (cpl_count)
    );

    typedef struct packed {
        logic [255:0] data;
        logic [7:0]   tag;
    } bd_t;

    typedef struct packed {
        logic [2:0] fmt;
        logic [4:0] typ;
        logic [9:0] len;
        logic [2:0] status;
        logic [7:0] tag;
        logic       head_last;
        logic [1:0] n_mid;
        logic [7:0] tail_keep;
        logic [1:0] exp_err;
        logic       err_on_last;
        logic       exp_bd;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    bd_t         bd_q[$];
    logic [1:0]  err_q[$];
    logic [15:0] exp_count = '0;
    bd_t         mon_bd;
    logic [1:0]  mon_err;
    vec_t        vecs[14];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] fmt, input logic [4:0] typ, input logic [9:0] len,
                                input logic [2:0] status, input logic [7:0] tag, input logic head_last,
                                input logic [1:0] n_mid, input logic [7:0] tail_keep,
                                input logic [1:0] exp_err, input logic err_on_last, input logic exp_bd);
        return '{fmt, typ, len, status, tag, head_last, n_mid, tail_keep, exp_err, err_on_last, exp_bd};
    endfunction

    // Header in DW0..2, payload DW0..4 above it; tail holds DW5..7 plus junk in unkept lanes.
    task automatic build(input vec_t v, output logic [255:0] b0, output logic [255:0] b1,
                         output logic [255:0] exp_d);
        logic [31:0] dw [8];
        for (int i = 0; i < 8; i++) begin
            dw[i] = (v.tag == 8'h5A) ? 32'(i + 1) : {v.tag, 8'h00, 16'(i + 1)};
        end
        b0 = {dw[4], dw[3], dw[2], dw[1], dw[0],
              {16'h1234, v.tag, 8'h00},
              {16'hABCD, v.status, 1'b0, 12'h020},
              {v.fmt, v.typ, 14'h0, v.len}};
        b1 = {{5{32'hDEADBEEF}}, dw[7], dw[6], dw[5]};
        exp_d = {dw[7], dw[6], dw[5], dw[4], dw[3], dw[2], dw[1], dw[0]};
    endtask

    // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
    task automatic drive_beat(input logic [255:0] d, input logic [7:0] k, input logic l);
        int gap;
        int n;
        gap = int'($urandom_range(0, 2));
        for (int i = 0; i < gap; i++) begin
            rx_tvalid = 1'b0;
            rx_tdata  = {8{$urandom}};
            rx_tlast  = 1'($urandom);
            rx_tkeep  = 8'($urandom);
            @(posedge user_clk); #1;
        end
        rx_tdata  = d;
        rx_tkeep  = k;
        rx_tlast  = l;
        rx_tvalid = 1'b1;
        n = 0;
        @(negedge user_clk);
        while (!rx_tready && n < 50) begin
            n++;
            @(negedge user_clk);
        end
        if (!rx_tready) begin
            checks++;
            failures++;
            $display("FAIL rx_accept_timeout actual=tready_low required=tready_high");
        end
        @(posedge user_clk); #1;
        rx_tvalid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [255:0] b0, b1, exp_d;
        build(v, b0, b1, exp_d);
        if (v.exp_err != 2'd0) err_q.push_back(v.exp_err);
        if (v.exp_bd) begin
            bd_q.push_back({exp_d, v.tag});
            exp_count++;
        end
        drive_beat(b0, 8'hFF, v.head_last);
        if (!v.head_last) begin
            for (int m = 0; m < int'(v.n_mid); m++) drive_beat(b1, 8'h07, 1'b0);
            drive_beat(b1, v.tail_keep, 1'b1);
        end
        @(negedge user_clk);
        check("bd_latency", 256'(bd_tvalid), 256'(v.exp_bd));
        check("err_timing", 256'(err_valid), 256'(v.err_on_last));
        repeat (3) @(negedge user_clk);
        #1;
        check("cpl_count", 256'(cpl_count), 256'(exp_count));
        check("sb_drained", 256'(bd_q.size() + err_q.size()), 256'(0));
        @(posedge user_clk); #1;
    endtask

    // Scoreboard monitor: pops expectations as the DUT produces descriptors and errors.
    always @(negedge user_clk) begin
        if (!user_reset) begin
            if (bd_tvalid && bd_tready) begin
                if (bd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL bd_unexpected actual=tag_%0h required=no_descriptor", bd_tag);
                end else begin
                    mon_bd = bd_q.pop_front();
                    check("bd_data", bd_tdata, mon_bd.data);
                    check("bd_tag", 256'(bd_tag), 256'(mon_bd.tag));
                end
            end
            if (err_valid) begin
                if (err_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL err_unexpected actual=code_%0d required=no_error", err_code);
                end else begin
                    mon_err = err_q.pop_front();
                    check("err_code", 256'(err_code), 256'(mon_err));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] b0, b1, exp_d;
        vec_t gv;

        vecs[0]  = mk(F_OK, T_OK,     10'd8, 3'd0, 8'h5A, 1'b0, 2'd0, 8'h07, 2'd0, 1'b0, 1'b1);
        vecs[1]  = mk(F_OK, T_OK,     10'd8, 3'd1, 8'h21, 1'b0, 2'd0, 8'h07, 2'd2, 1'b0, 1'b0);
        vecs[2]  = mk(F_OK, T_OK,     10'd4, 3'd0, 8'h22, 1'b0, 2'd2, 8'h07, 2'd1, 1'b0, 1'b0);
        vecs[3]  = mk(F_OK, T_OK,     10'd8, 3'd0, 8'h33, 1'b0, 2'd0, 8'h07, 2'd0, 1'b0, 1'b1);
        vecs[4]  = mk(3'b000, T_OK,   10'd8, 3'd0, 8'h24, 1'b0, 2'd0, 8'h07, 2'd1, 1'b0, 1'b0);
        vecs[5]  = mk(F_OK, 5'b01011, 10'd8, 3'd0, 8'h25, 1'b0, 2'd0, 8'h07, 2'd1, 1'b0, 1'b0);
        vecs[6]  = mk(F_OK, T_OK,     10'd4, 3'd1, 8'h26, 1'b0, 2'd0, 8'h07, 2'd1, 1'b0, 1'b0);
        vecs[7]  = mk(F_OK, T_OK,     10'd8, 3'd0, 8'h27, 1'b1, 2'd0, 8'h07, 2'd3, 1'b1, 1'b0);
        vecs[8]  = mk(F_OK, T_OK,     10'd8, 3'd2, 8'h28, 1'b1, 2'd0, 8'h07, 2'd2, 1'b1, 1'b0);
        vecs[9]  = mk(3'b000, T_OK,   10'd8, 3'd0, 8'h29, 1'b1, 2'd0, 8'h07, 2'd1, 1'b1, 1'b0);
        vecs[10] = mk(F_OK, T_OK,     10'd8, 3'd0, 8'h2A, 1'b0, 2'd0, 8'h0F, 2'd3, 1'b1, 1'b0);
        vecs[11] = mk(F_OK, T_OK,     10'd8, 3'd0, 8'h2B, 1'b0, 2'd1, 8'h07, 2'd3, 1'b0, 1'b0);
        vecs[12] = mk(F_OK, 5'b01011, 10'd8, 3'd4, 8'h2C, 1'b1, 2'd0, 8'h07, 2'd1, 1'b1, 1'b0);
        vecs[13] = mk(F_OK, T_OK,     10'd8, 3'd0, 8'hA5, 1'b0, 2'd0, 8'h07, 2'd0, 1'b0, 1'b1);

        // Reset values while reset is held.
        repeat (3) @(posedge user_clk);
        @(negedge user_clk);
        check("rst_rx_tready", 256'(rx_tready), 256'(0));
        check("rst_bd_tvalid", 256'(bd_tvalid), 256'(0));
        check("rst_bd_tdata", bd_tdata, 256'(0));
        check("rst_bd_tag", 256'(bd_tag), 256'(0));
        check("rst_err_valid", 256'(err_valid), 256'(0));
        check("rst_err_code", 256'(err_code), 256'(0));
        check("rst_cpl_count", 256'(cpl_count), 256'(0));
        @(posedge user_clk); #1;
        user_reset = 1'b0;
        @(posedge user_clk); #1;
        @(negedge user_clk);
        check("post_rst_rx_tready", 256'(rx_tready), 256'(1));
        @(posedge user_clk); #1;

        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        // Backpressure: descriptor held for 10 cycles with input closed.
        gv = mk(F_OK, T_OK, 10'd8, 3'd0, 8'hC3, 1'b0, 2'd0, 8'h07, 2'd0, 1'b0, 1'b1);
        build(gv, b0, b1, exp_d);
        bd_tready = 1'b0;
        bd_q.push_back({exp_d, gv.tag});
        exp_count++;
        drive_beat(b0, 8'hFF, 1'b0);
        drive_beat(b1, 8'h07, 1'b1);
        for (int c = 0; c < 10; c++) begin
            @(negedge user_clk);
            check("bp_rx_tready", 256'(rx_tready), 256'(0));
            check("bp_bd_tvalid", 256'(bd_tvalid), 256'(1));
            check("bp_bd_tdata", bd_tdata, exp_d);
            check("bp_bd_tag", 256'(bd_tag), 256'(8'hC3));
        end
        @(posedge user_clk); #1;
        bd_tready = 1'b1;
        @(posedge user_clk); #1;
        @(negedge user_clk);
        check("bp_back_idle_rx_tready", 256'(rx_tready), 256'(1));
        check("bp_bd_tvalid_low", 256'(bd_tvalid), 256'(0));
        check("bp_cpl_count", 256'(cpl_count), 256'(exp_count));
        @(posedge user_clk); #1;

        // Reset pulsed while waiting for the tail: partial descriptor discarded silently.
        gv = mk(F_OK, T_OK, 10'd8, 3'd0, 8'h77, 1'b0, 2'd0, 8'h07, 2'd0, 1'b0, 1'b1);
        build(gv, b0, b1, exp_d);
        drive_beat(b0, 8'hFF, 1'b0);
        user_reset = 1'b1;
        @(posedge user_clk); #1;
        user_reset = 1'b0;
        exp_count = '0;
        @(posedge user_clk); #1;
        @(negedge user_clk);
        check("mid_rst_bd_tvalid", 256'(bd_tvalid), 256'(0));
        check("mid_rst_err_valid", 256'(err_valid), 256'(0));
        check("mid_rst_rx_tready", 256'(rx_tready), 256'(1));
        check("mid_rst_cpl_count", 256'(cpl_count), 256'(0));
        @(posedge user_clk); #1;
        run_vec(mk(F_OK, T_OK, 10'd8, 3'd0, 8'h66, 1'b0, 2'd0, 8'h07, 2'd0, 1'b0, 1'b1));

        // Counter wrap: preload to 16'hFFFF, one more completion wraps to zero.
        force dut.cpl_count_q = 16'hFFFF;
        @(posedge user_clk); #1;
        release dut.cpl_count_q;
        exp_count = 16'hFFFF;
        @(negedge user_clk);
        check("preload_cpl_count", 256'(cpl_count), 256'(16'hFFFF));
        @(posedge user_clk); #1;
        run_vec(vecs[0]);

        check("final_drain", 256'(bd_q.size() + err_q.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
